// File: rtl/ha_array_seq_ctrl.sv
// Multi-cycle sequencer for the 8x8 ha_array PPG: registers operands, accumulates 2-row groups, returns product.
// Optional error-compensation bias is enabled by defining HA_ARRAY_BIAS_COMP_EN.
module ha_array_seq_ctrl #(
    parameter int          ACC_W      = 17,
    parameter int          EARLY_TERM = 1,
    parameter int unsigned BIAS       = 19
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_x,
    input  logic [7:0]  in_y,
    output logic [7:0]  ppg_x,
    output logic [7:0]  ppg_y,
    input  logic [6:0]  ppg_b_0,
    input  logic [6:0]  ppg_b_1,
    input  logic [6:0]  ppg_b_2,
    input  logic [6:0]  ppg_b_3,
    input  logic [8:0]  ppg_t_0,
    input  logic [8:0]  ppg_t_1,
    input  logic [8:0]  ppg_t_2,
    input  logic [8:0]  ppg_t_3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        busy,
    output logic [1:0]  grp_idx
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [ACC_W-1:0]   acc_r;
    logic [7:0]         ppg_x_r;
    logic [7:0]         ppg_y_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [15:0]        result_r;
    logic               busy_r;
    logic [1:0]         grp_idx_r;

    logic [6:0]         grp_b_s;
    logic [8:0]         grp_t_s;
    logic [9:0]         grp_val_s;
    logic [15:0]        shifted_s;
    logic [ACC_W-1:0]   acc_next_s;
    logic               upper_zero_s;
    logic               last_grp_s;
    logic [15:0]        res_s;
`ifdef HA_ARRAY_BIAS_COMP_EN
    logic [ACC_W:0]     biased_s;
`endif

    // Select the active group's rows and align the group value at offset 2*grp_idx.
    always_comb begin
        grp_b_s      = 7'd0;
        grp_t_s      = 9'd0;
        shifted_s    = 16'd0;
        upper_zero_s = 1'b1;
        case (grp_idx_r)
            2'd0: begin
                grp_b_s      = ppg_b_0;
                grp_t_s      = ppg_t_0;
                upper_zero_s = (ppg_x_r[7:2] == 6'd0);
            end
            2'd1: begin
                grp_b_s      = ppg_b_1;
                grp_t_s      = ppg_t_1;
                upper_zero_s = (ppg_x_r[7:4] == 4'd0);
            end
            2'd2: begin
                grp_b_s      = ppg_b_2;
                grp_t_s      = ppg_t_2;
                upper_zero_s = (ppg_x_r[7:6] == 2'd0);
            end
            default: begin
                grp_b_s      = ppg_b_3;
                grp_t_s      = ppg_t_3;
                upper_zero_s = 1'b1;
            end
        endcase
        grp_val_s = {1'b0, grp_t_s} + {1'b0, grp_b_s, 2'b00};
        case (grp_idx_r)
            2'd0:    shifted_s = {6'd0, grp_val_s};
            2'd1:    shifted_s = {4'd0, grp_val_s, 2'd0};
            2'd2:    shifted_s = {2'd0, grp_val_s, 4'd0};
            default: shifted_s = {grp_val_s, 6'd0};
        endcase
        acc_next_s = acc_r + ACC_W'(shifted_s);
        last_grp_s = (grp_idx_r == 2'd3) || ((EARLY_TERM != 0) && upper_zero_s);
    end

    // Saturated (and optionally bias-compensated) result captured on the ACC-to-DONE transition.
    always_comb begin
`ifdef HA_ARRAY_BIAS_COMP_EN
        biased_s = {1'b0, acc_next_s} + (ACC_W + 1)'(BIAS);
        if ((ppg_x_r == 8'd0) || (ppg_y_r == 8'd0)) begin
            res_s = 16'd0;
        end else if (|biased_s[ACC_W:16]) begin
            res_s = 16'hFFFF;
        end else begin
            res_s = biased_s[15:0];
        end
`else
        if (|acc_next_s[ACC_W-1:16]) begin
            res_s = 16'hFFFF;
        end else begin
            res_s = acc_next_s[15:0];
        end
`endif
    end

    // Transaction FSM with registered handshake, operand and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            acc_r       <= '0;
            ppg_x_r     <= 8'd0;
            ppg_y_r     <= 8'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= 16'd0;
            busy_r      <= 1'b0;
            grp_idx_r   <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        ppg_x_r    <= in_x;
                        ppg_y_r    <= in_y;
                        acc_r      <= '0;
                        grp_idx_r  <= 2'd0;
                        busy_r     <= 1'b1;
                        in_ready_r <= 1'b0;
                        state_r    <= ST_ACC;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ST_ACC: begin
                    acc_r <= acc_next_s;
                    if (last_grp_s) begin
                        result_r    <= res_s;
                        out_valid_r <= 1'b1;
                        grp_idx_r   <= 2'd0;
                        state_r     <= ST_DONE;
                    end else begin
                        grp_idx_r <= grp_idx_r + 2'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    grp_idx_r   <= 2'd0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign ppg_x     = ppg_x_r;
    assign ppg_y     = ppg_y_r;
    assign busy      = busy_r;
    assign grp_idx   = grp_idx_r;

endmodule

// File: tb/tb_ha_array_seq_ctrl.sv
// Directed, table-driven bench for ha_array_seq_ctrl with a behavioural half-adder-array PPG model.
module tb_ha_array_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_x;
    logic [7:0]  in_y;
    logic [7:0]  ppg_x;
    logic [7:0]  ppg_y;
    logic [6:0]  ppg_b_0, ppg_b_1, ppg_b_2, ppg_b_3;
    logic [8:0]  ppg_t_0, ppg_t_1, ppg_t_2, ppg_t_3;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        busy;
    logic [1:0]  grp_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Two PPG rows reduced by half adders: t = sums (weight i), b = carries (weight j+2).
    function automatic logic [15:0] ha_grp(input logic [1:0] xs, input logic [7:0] y);
        logic [8:0] r0, r1, t, c;
        r0 = xs[0] ? {1'b0, y} : 9'd0;
        r1 = xs[1] ? {y, 1'b0} : 9'd0;
        t  = r0 ^ r1;
        c  = r0 & r1;
        return {c[7:1], t};
    endfunction

    assign {ppg_b_0, ppg_t_0} = ha_grp(ppg_x[1:0], ppg_y);
    assign {ppg_b_1, ppg_t_1} = ha_grp(ppg_x[3:2], ppg_y);
    assign {ppg_b_2, ppg_t_2} = ha_grp(ppg_x[5:4], ppg_y);
    assign {ppg_b_3, ppg_t_3} = ha_grp(ppg_x[7:6], ppg_y);

    ha_array_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .ppg_x     (ppg_x),
        .ppg_y     (ppg_y),
        .ppg_b_0   (ppg_b_0),
        .ppg_b_1   (ppg_b_1),
        .ppg_b_2   (ppg_b_2),
        .ppg_b_3   (ppg_b_3),
        .ppg_t_0   (ppg_t_0),
        .ppg_t_1   (ppg_t_1),
        .ppg_t_2   (ppg_t_2),
        .ppg_t_3   (ppg_t_3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy),
        .grp_idx   (grp_idx)
    );

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        int          prod;
        int          n_acc;
    } vec_t;

    vec_t vecs[7];

    function automatic int exp_res(input logic [7:0] x, input logic [7:0] y, input int prod);
`ifdef HA_ARRAY_BIAS_COMP_EN
        if (x == 8'd0 || y == 8'd0) return 0;
        return (prod + 19 > 65535) ? 65535 : prod + 19;
`else
        return prod;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [7:0] x, input logic [7:0] y, input int prod, input int n);
        int cyc;
        int busy_cnt;
        in_x      = x;
        in_y      = y;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check("in_ready_idle", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
        in_x     = 8'hAA;
        in_y     = 8'h55;
        cyc      = 1;
        busy_cnt = 0;
        while (!out_valid && cyc < 20) begin
            busy_cnt += int'(busy);
            step();
            cyc++;
        end
        busy_cnt += int'(busy);
        check("latency", cyc, n + 1);
        check("result", int'(result), exp_res(x, y, prod));
        check("busy_cycles", busy_cnt, n + 1);
        step();
        check("out_valid_drop", int'(out_valid), 0);
        check("in_ready_back", int'(in_ready), 1);
        check("busy_idle", int'(busy), 0);
    endtask

    initial begin
        int cyc;
        vecs[0] = '{8'd4,   8'd3,   12,    2};
        vecs[1] = '{8'd128, 8'd1,   128,   4};
        vecs[2] = '{8'd0,   8'd255, 0,     1};
        vecs[3] = '{8'd255, 8'd255, 65025, 4};
        vecs[4] = '{8'd3,   8'd200, 600,   1};
        vecs[5] = '{8'd16,  8'd10,  160,   3};
        vecs[6] = '{8'd12,  8'd7,   84,    2};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = 8'd0;
        in_y      = 8'd0;
        out_ready = 1'b1;
        #12;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_result", int'(result), 0);
        check("rst_ppg_x", int'(ppg_x), 0);
        check("rst_ppg_y", int'(ppg_y), 0);
        check("rst_grp_idx", int'(grp_idx), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].x, vecs[i].y, vecs[i].prod, vecs[i].n_acc);
        end

        // Consumer stall: result held, new requests ignored.
        in_x      = 8'd4;
        in_y      = 8'd3;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        check("stall_valid_seen", int'(out_valid), 1);
        for (int i = 0; i < 3; i++) begin
            in_valid = (i % 2 == 0) ? 1'b1 : 1'b0;
            in_x     = 8'd9;
            in_y     = 8'd9;
            check("stall_result", int'(result), exp_res(8'd4, 8'd3, 12));
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_out_valid", int'(out_valid), 1);
            step();
        end
        in_valid  = 1'b0;
        check("stall_result_end", int'(result), exp_res(8'd4, 8'd3, 12));
        out_ready = 1'b1;
        step();
        check("stall_release_valid", int'(out_valid), 0);
        check("stall_release_ready", int'(in_ready), 1);
        check("stall_ppg_x_kept", int'(ppg_x), 4);

        // Asynchronous reset mid-transaction.
        in_x     = 8'd128;
        in_y     = 8'd1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        cyc = 0;
        while (grp_idx != 2'd2 && cyc < 10) begin
            step();
            cyc++;
        end
        check("rst_mid_grp2", int'(grp_idx), 2);
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", int'(out_valid), 0);
        check("rst_mid_result", int'(result), 0);
        check("rst_mid_ppg_x", int'(ppg_x), 0);
        check("rst_mid_grp_idx", int'(grp_idx), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_in_ready", int'(in_ready), 1);
        #1;
        rst_n = 1'b1;
        step();
        run_txn(8'd4, 8'd3, 12, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
